pf_region_ctrl: RTL

- Upstream command source for the prefetcher interface of the ICACHE_MP_128_PF private prefetch path.
- Takes one software-programmed prefetch region (byte address + byte length) and splits it into line-aligned commands of at most MAX_LINES cache lines (16 B lines).
- Each command is sent as {pf_addr, pf_size = lines-1} over a req/ack handshake.
- Tracks the prefetcher's completion pulse so software can see busy/done for the whole region.

---
 rtl/pf_region_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pf_region_ctrl.sv
// pf_region_ctrl
// Splits one software-programmed prefetch region (byte address + byte length)
// into line-aligned prefetch commands of at most MAX_LINES 16-byte lines.
// The commands go out over a req/ack handshake. The controller then waits
// for the prefetcher's completion pulse before it reports the region as done.
//
// Optional feature: define PF_REGION_PERF_EN to add the performance counters
// perf_cycles_o and perf_cmds_o.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         one-cycle pulse; latch addr_i/len_i and begin (IDLE only)
//   addr_i, len_i   region start byte address and byte length (0 = empty)
//   abort_i         stop issuing new commands
//   busy_o          high whenever the FSM is not in IDLE
//   done_o          one-cycle completion pulse
//   pf_req_o        command valid
//   pf_addr_o       line-aligned command address
//   pf_size_o       lines in command minus 1
//   pf_ack_i        command accepted by the prefetcher
//   pf_done_i       prefetcher completion pulse
//   perf_cycles_o   (PF_REGION_PERF_EN) cycles spent busy, saturating
//   perf_cmds_o     (PF_REGION_PERF_EN) acked commands, saturating
module pf_region_ctrl #(
  parameter int MAX_LINES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [19:0] len_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pf_req_o,
  output logic [31:0] pf_addr_o,
  output logic [7:0]  pf_size_o,
  input  logic        pf_ack_i,
  input  logic        pf_done_i
`ifdef PF_REGION_PERF_EN
  ,
  output logic [31:0] perf_cycles_o,
  output logic [15:0] perf_cmds_o
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETUP     = 2'd1,
    ISSUE     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [16:0] MAX_CHUNK = 17'(MAX_LINES);

  state_t      state, nxt_state;
  logic [31:0] cur_addr, nxt_addr;
  logic [16:0] remaining, nxt_remaining;
  logic        issued, nxt_issued;
  logic        done_r, nxt_done;

  logic [16:0] chunk;
  logic [16:0] chunk_m1;
  logic [16:0] lines_calc;

  // Line count is last line index minus first line index plus one. The end
  // address is formed in 33 bits so a region that runs past 2^32 still counts
  // correctly. Only the low 17 bits of the difference are meaningful.
  assign lines_calc = (len_i == 20'd0) ? 17'd0 :
                      17'(({1'b0, addr_i} + {13'd0, len_i} - 33'd1) >> 4)
                      - 17'(addr_i >> 4) + 17'd1;

  assign chunk    = (remaining > MAX_CHUNK) ? MAX_CHUNK : remaining;
  assign chunk_m1 = chunk - 17'd1;

  // State and datapath registers. Reset drops any region in flight silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= 32'd0;
      remaining <= 17'd0;
      issued    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state     <= nxt_state;
      cur_addr  <= nxt_addr;
      remaining <= nxt_remaining;
      issued    <= nxt_issued;
      done_r    <= nxt_done;
    end
  end

  // Next-state logic. In ISSUE an ack always completes the presented command
  // before an abort is honoured. The command registers only change on an ack,
  // so req/addr/size hold stable while the prefetcher stalls.
  always_comb begin
    nxt_state     = state;
    nxt_addr      = cur_addr;
    nxt_remaining = remaining;
    nxt_issued    = issued;
    nxt_done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          nxt_addr      = {addr_i[31:4], 4'b0000};
          nxt_remaining = lines_calc;
          nxt_issued    = 1'b0;
          nxt_state     = SETUP;
        end
      end
      SETUP: begin
        nxt_state = (remaining == 17'd0) ? IDLE : ISSUE;
      end
      ISSUE: begin
        if (pf_ack_i) begin
          nxt_addr      = cur_addr + {11'd0, chunk, 4'b0000};
          nxt_remaining = remaining - chunk;
          nxt_issued    = 1'b1;
          if ((remaining == chunk) || abort_i) begin
            nxt_state = WAIT_DONE;
          end
        end else if (abort_i) begin
          if (issued) begin
            nxt_state = WAIT_DONE;
          end else begin
            nxt_state = IDLE;
            nxt_done  = 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        // Any pf_done_i seen here is strictly after the final ack, because
        // that ack was taken while still in ISSUE.
        if (pf_done_i) begin
          nxt_state = IDLE;
          nxt_done  = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // An empty region completes directly from SETUP, so its done pulse is
  // decoded from state. The other completions come from the registered
  // pulse, which lines up with the return to IDLE.
  always_comb begin
    busy_o    = (state != IDLE);
    done_o    = done_r | ((state == SETUP) && (remaining == 17'd0));
    pf_req_o  = (state == ISSUE);
    pf_addr_o = (state == ISSUE) ? cur_addr : 32'd0;
    pf_size_o = (state == ISSUE) ? chunk_m1[7:0] : 8'd0;
  end

`ifdef PF_REGION_PERF_EN
  // Saturating counters. They clear when a new region is accepted and hold
  // their values after completion so software can read them afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_o <= 32'd0;
      perf_cmds_o   <= 16'd0;
    end else if ((state == IDLE) && start_i) begin
      perf_cycles_o <= 32'd0;
      perf_cmds_o   <= 16'd0;
    end else begin
      if (busy_o && (perf_cycles_o != 32'hFFFF_FFFF)) begin
        perf_cycles_o <= perf_cycles_o + 32'd1;
      end
      if ((state == ISSUE) && pf_ack_i && (perf_cmds_o != 16'hFFFF)) begin
        perf_cmds_o <= perf_cmds_o + 16'd1;
      end
    end
  end
`endif

endmodule
